// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin with bus parking, one all-high GNT
// cycle on every hand-over, hidden arbitration during transfers and an
// idle-owner timeout that revokes a grant from a master that never starts.

// One registered active-low GNT line.
module pci_arb_gnt_lane #(
    parameter int IDX = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       grant_en,
    input  logic [2:0] owner_nxt,
    output logic       gnt
);
    // Pull low only when the arbiter enters/stays in GRANT with this master as owner.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) gnt <= 1'b1;
        else     gnt <= !(grant_en && owner_nxt == 3'(IDX));
    end
endmodule

module pci_bus_arbiter #(
    parameter int N_MASTERS    = 4,
    parameter int PARK_MASTER  = 0,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] REQ,
    input  logic                 FRAME,
    input  logic                 IRDY,
    output logic [N_MASTERS-1:0] GNT,
    output logic [2:0]           GNT_OWNER,
    output logic                 GNT_VALID,
    output logic                 TIMEOUT_EVT
);
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [2:0] PARK     = 3'(PARK_MASTER);
    localparam logic [4:0] TMO_LAST = 5'(IDLE_TIMEOUT - 1);
    localparam logic [3:0] NM       = 4'(N_MASTERS);

    state_t     state, state_nxt;
    logic [2:0] owner, owner_nxt, next_q, next_nxt;
    logic [2:0] other_idx, owner_inc;
    logic [3:0] probe;
    logic [7:0] req_on;
    logic [4:0] idle_cnt, idle_cnt_nxt;
    logic       started, started_nxt, idle_q, idle;
    logic       owner_req, other_found, grant_en;
    logic       tmo_nxt, valid_q, tmo_q;

    assign idle      = FRAME & IRDY;
    assign owner_req = req_on[owner];
    assign owner_inc = (owner == 3'(N_MASTERS - 1)) ? 3'd0 : owner + 3'd1;
    assign grant_en  = (state_nxt == ST_GRANT);

    // Active-high requests padded to 8 so a 3-bit owner index is always in range.
    always_comb begin
        req_on = 8'h00;
        for (int i = 0; i < N_MASTERS; i++) req_on[i] = ~REQ[i];
    end

    // Nearest requester after the owner (owner excluded); walk far-to-near so the closest wins.
    always_comb begin
        other_found = 1'b0;
        other_idx   = 3'd0;
        probe       = 4'd0;
        for (int k = N_MASTERS - 1; k >= 1; k--) begin
            probe = {1'b0, owner} + 4'(k);
            if (probe >= NM) probe = probe - NM;
            if (req_on[probe[2:0]]) begin
                other_found = 1'b1;
                other_idx   = probe[2:0];
            end
        end
    end

    // Next-state, hand-over target, transaction-start flag and idle counter.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        next_nxt     = next_q;
        started_nxt  = started;
        idle_cnt_nxt = idle_cnt;
        tmo_nxt      = 1'b0;
        case (state)
            ST_INIT: begin
                state_nxt = ST_GRANT;
                owner_nxt = PARK;
            end
            ST_GRANT: begin
                if (!FRAME || !owner_req)
                    idle_cnt_nxt = 5'd0;
                else if (idle && !started && idle_cnt != 5'd31)
                    idle_cnt_nxt = idle_cnt + 5'd1;
                // A FRAME falling out of an idle bus marks the owner's transaction start.
                if (idle_q && !FRAME) started_nxt = 1'b1;
                // A real switch outranks a timeout in the same cycle.
                if (other_found && (!owner_req || started)) begin
                    state_nxt = ST_SWITCH;
                    next_nxt  = other_idx;
                end else if (owner_req && !started && idle && idle_cnt >= TMO_LAST) begin
                    state_nxt = ST_SWITCH;
                    tmo_nxt   = 1'b1;
                    next_nxt  = other_found ? other_idx : owner_inc;
                end
                if (state_nxt == ST_SWITCH) begin
                    started_nxt  = 1'b0;
                    idle_cnt_nxt = 5'd0;
                end
            end
            ST_SWITCH: begin
                // Hand over even if the target has dropped REQ; it is then parked.
                state_nxt    = ST_GRANT;
                owner_nxt    = next_q;
                started_nxt  = 1'b0;
                idle_cnt_nxt = 5'd0;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_INIT;
            owner    <= PARK;
            next_q   <= PARK;
            started  <= 1'b0;
            idle_q   <= 1'b1;
            idle_cnt <= 5'd0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            next_q   <= next_nxt;
            started  <= started_nxt;
            idle_q   <= idle;
            idle_cnt <= idle_cnt_nxt;
            valid_q  <= grant_en;
            tmo_q    <= tmo_nxt;
        end
    end

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_lane
        pci_arb_gnt_lane #(.IDX(g)) u_lane (
            .CLK       (CLK),
            .RST       (RST),
            .grant_en  (grant_en),
            .owner_nxt (owner_nxt),
            .gnt       (GNT[g])
        );
    end

    assign GNT_OWNER   = owner;
    assign GNT_VALID   = valid_q;
    assign TIMEOUT_EVT = tmo_q;
endmodule
